vanilla_decode_queue: RTL and testbench

VANILLA_DECODE_QUEUE -- requirements
Module: vanilla_decode_queue

---
 rtl/vanilla_decode_queue.sv | 207 ++++++++++++++++++++
 tb/tb_vanilla_decode_queue.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vanilla_decode_queue.sv
// vanilla_decode_queue
//   Small instruction queue between fetch and issue. Each RV32 instruction is
//   decoded when it is enqueued, and the 12 decode flags are stored with it.
//   Issue is held back in three cases: a fence is waiting for memory ops to
//   drain, a memory op would exceed the outstanding limit, or the FSM is in
//   FENCE_WAIT.
//
// Ports
//   clk_i, reset_n_i               clock, asynchronous active-low reset
//   instr_v_i/instr_i/pc_i         enqueue side; instr_ready_o = not full
//   flush_i                        drop every queued entry, FSM back to RUN
//   dec_v_o/dec_instr_o/dec_pc_o   head entry presented to the consumer
//   dec_flags_o                    stored decode flags of the head entry
//   dec_yumi_i                     consumer takes the head (only when dec_v_o)
//   mem_resp_v_i                   one memory op retired
//   outstanding_o                  number of issued memory ops not yet retired
//   fence_stall_o                  FSM is in FENCE_WAIT
//   err_o                          sticky: a response arrived with nothing outstanding
module vanilla_decode_queue #(
    parameter int els_p      = 4,
    parameter int pc_width_p = 24,
    parameter int max_out_p  = 15,
    localparam int cnt_w     = $clog2(max_out_p + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  instr_v_i,
    input  logic [31:0]           instr_i,
    input  logic [pc_width_p-1:0] pc_i,
    output logic                  instr_ready_o,
    input  logic                  flush_i,
    output logic                  dec_v_o,
    output logic [31:0]           dec_instr_o,
    output logic [pc_width_p-1:0] dec_pc_o,
    output logic [11:0]           dec_flags_o,
    input  logic                  dec_yumi_i,
    input  logic                  mem_resp_v_i,
    output logic [cnt_w-1:0]      outstanding_o,
    output logic                  fence_stall_o,
    output logic                  err_o
);

    localparam int ptr_w = $clog2(els_p);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AMO      = 7'b0101111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    typedef enum logic {RUN, FENCE_WAIT} state_t;

    function automatic logic [11:0] decode_flags(input logic [31:0] ins);
        logic [6:0]  op;
        logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld;
        logic        is_st, is_op, is_opi, is_amo, is_misc;
        logic [11:0] f;
        op       = ins[6:0];
        is_lui   = (op == OPC_LUI);
        is_auipc = (op == OPC_AUIPC);
        is_jal   = (op == OPC_JAL);
        is_jalr  = (op == OPC_JALR);
        is_br    = (op == OPC_BRANCH);
        is_ld    = (op == OPC_LOAD);
        is_st    = (op == OPC_STORE);
        is_op    = (op == OPC_OP);
        is_opi   = (op == OPC_OP_IMM);
        is_amo   = (op == OPC_AMO);
        is_misc  = (op == OPC_MISC_MEM);
        f        = '0;
        f[0]  = (ins[11:7] != 5'd0) &
                (is_lui | is_auipc | is_jal | is_jalr | is_ld | is_op | is_opi | is_amo);
        f[1]  = is_ld | is_st | is_amo;
        f[2]  = is_ld | is_amo;
        f[3]  = is_st;
        f[4]  = is_br;
        f[5]  = is_jal | is_jalr;
        f[6]  = is_jalr | is_br | is_ld | is_st | is_op | is_opi | is_amo;
        f[7]  = is_br | is_st | is_op | (is_amo & (ins[31:27] == 5'b00001));
        f[8]  = is_auipc;
        f[9]  = is_op & (ins[31:25] == 7'b0000001) & (ins[14:12] != 3'b000);
        // fence / fence.i must have zero rs1/rd and the reserved upper bits clear
        f[10] = is_misc & (ins[14:12] == 3'b000) & (ins[19:15] == 5'd0) &
                (ins[11:7] == 5'd0) & (ins[31:28] == 4'd0);
        f[11] = is_misc & (ins[14:12] == 3'b001) & (ins[19:15] == 5'd0) &
                (ins[11:7] == 5'd0) & (ins[31:20] == 12'd0);
        return f;
    endfunction

    logic [31:0]           r_instr [els_p];
    logic [pc_width_p-1:0] r_pc    [els_p];
    logic [11:0]           r_flags [els_p];
    logic [ptr_w-1:0]      r_rd_ptr, r_wr_ptr;
    logic [ptr_w:0]        r_count;
    logic [cnt_w-1:0]      r_out;
    logic                  r_err;
    state_t                r_state;
    logic                  r_fence_stall;

    logic        w_empty, w_full, w_enq, w_deq, w_inc;
    logic        w_head_fence, w_head_mem, w_out_zero, w_out_max;
    logic [11:0] w_head_flags;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == (ptr_w+1)'(els_p));
    assign w_head_flags = r_flags[r_rd_ptr];
    assign w_head_fence = ~w_empty & (w_head_flags[10] | w_head_flags[11]);
    assign w_head_mem   = ~w_empty & w_head_flags[1];
    assign w_out_zero   = (r_out == '0);
    assign w_out_max    = (r_out == cnt_w'(max_out_p));

    // ready looks only at occupancy, never at dec_yumi_i
    assign instr_ready_o = ~w_full;
    assign dec_v_o       = ~w_empty & (r_state == RUN) &
                           ~(w_head_fence & ~w_out_zero) &
                           ~(w_head_mem & w_out_max);
    assign dec_instr_o   = r_instr[r_rd_ptr];
    assign dec_pc_o      = r_pc[r_rd_ptr];
    assign dec_flags_o   = w_head_flags;

    // a flush cycle neither accepts a new entry nor retires the head
    assign w_enq = instr_v_i & ~w_full & ~flush_i;
    assign w_deq = dec_v_o & dec_yumi_i & ~flush_i;
    assign w_inc = w_deq & w_head_flags[1];

    assign outstanding_o = r_out;
    assign fence_stall_o = r_fence_stall;
    assign err_o         = r_err;

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_instr[r_wr_ptr] <= instr_i;
            r_pc[r_wr_ptr]    <= pc_i;
            r_flags[r_wr_ptr] <= decode_flags(instr_i);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + ptr_w'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + ptr_w'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (ptr_w+1)'(1);
                2'b01:   r_count <= r_count - (ptr_w+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Outstanding memory ops; flush does not touch this count.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_out <= '0;
            r_err <= 1'b0;
        end else if (w_inc & ~mem_resp_v_i) begin
            r_out <= r_out + cnt_w'(1);
        end else if (~w_inc & mem_resp_v_i) begin
            if (w_out_zero) r_err <= 1'b1;
            else            r_out <= r_out - cnt_w'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state       <= RUN;
            r_fence_stall <= 1'b0;
        end else if (flush_i) begin
            r_state       <= RUN;
            r_fence_stall <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_head_fence & ~w_out_zero) begin
                        r_state       <= FENCE_WAIT;
                        r_fence_stall <= 1'b1;
                    end
                end
                FENCE_WAIT: begin
                    // leave one cycle after the count has drained
                    if (w_out_zero) begin
                        r_state       <= RUN;
                        r_fence_stall <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= RUN;
                    r_fence_stall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vanilla_decode_queue.sv
// Randomized + directed bench for vanilla_decode_queue against a queue-based
// behavioural model. DUT built with els_p=4, max_out_p=2.
module tb_vanilla_decode_queue;

    localparam int ELS  = 4;
    localparam int PCW  = 24;
    localparam int MAXO = 2;
    localparam int CW   = $clog2(MAXO + 1);

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011,
                           STORE = 7'b0100011, OPR = 7'b0110011, OPI = 7'b0010011,
                           AMO = 7'b0101111, MISC = 7'b0001111;

    localparam logic [31:0] ADD   = 32'h003100B3;
    localparam logic [31:0] LW    = {12'd4, 5'd2, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] SW    = {7'd0, 5'd5, 5'd2, 3'b010, 5'd8, 7'b0100011};
    localparam logic [31:0] FENCE = 32'h0000000F;

    logic           clk_i = 1'b0;
    logic           reset_n_i = 1'b1;
    logic           instr_v_i = 1'b0;
    logic [31:0]    instr_i = '0;
    logic [PCW-1:0] pc_i = '0;
    logic           flush_i = 1'b0;
    logic           dec_yumi_i = 1'b0;
    logic           mem_resp_v_i = 1'b0;
    logic           instr_ready_o, dec_v_o, fence_stall_o, err_o;
    logic [31:0]    dec_instr_o;
    logic [PCW-1:0] dec_pc_o;
    logic [11:0]    dec_flags_o;
    logic [CW-1:0]  outstanding_o;

    always #5 clk_i = ~clk_i;

    vanilla_decode_queue #(.els_p(ELS), .pc_width_p(PCW), .max_out_p(MAXO)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .instr_v_i(instr_v_i), .instr_i(instr_i), .pc_i(pc_i),
        .instr_ready_o(instr_ready_o), .flush_i(flush_i),
        .dec_v_o(dec_v_o), .dec_instr_o(dec_instr_o), .dec_pc_o(dec_pc_o),
        .dec_flags_o(dec_flags_o), .dec_yumi_i(dec_yumi_i),
        .mem_resp_v_i(mem_resp_v_i), .outstanding_o(outstanding_o),
        .fence_stall_o(fence_stall_o), .err_o(err_o)
    );

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0]    ins;
        logic [PCW-1:0] pc;
    } ent_t;

    ent_t q[$];
    int   m_out = 0;
    bit   m_err = 0;
    bit   m_fw  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Flag table written straight from the opcode/field rules.
    function automatic logic [11:0] ref_flags(input logic [31:0] w);
        logic [6:0]  op;
        logic [11:0] f;
        op = w[6:0];
        f  = '0;
        f[0]  = (w[11:7] != 0) && (op inside {LUI, AUIPC, JAL, JALR, LOAD, OPR, OPI, AMO});
        f[1]  = op inside {LOAD, STORE, AMO};
        f[2]  = op inside {LOAD, AMO};
        f[3]  = (op == STORE);
        f[4]  = (op == BRANCH);
        f[5]  = op inside {JAL, JALR};
        f[6]  = op inside {JALR, BRANCH, LOAD, STORE, OPR, OPI, AMO};
        f[7]  = (op inside {BRANCH, STORE, OPR}) || (op == AMO && w[31:27] == 5'b00001);
        f[8]  = (op == AUIPC);
        f[9]  = (op == OPR) && (w[31:25] == 7'b0000001) && (w[14:12] != 0);
        f[10] = (op == MISC) && (w[14:12] == 0) && (w[19:15] == 0) && (w[11:7] == 0) && (w[31:28] == 0);
        f[11] = (op == MISC) && (w[14:12] == 1) && (w[19:15] == 0) && (w[11:7] == 0) && (w[31:20] == 0);
        return f;
    endfunction

    function automatic bit m_dv();
        logic [11:0] f;
        if (q.size() == 0) return 0;
        if (m_fw) return 0;
        f = ref_flags(q[0].ins);
        if ((f[10] || f[11]) && m_out != 0) return 0;
        if (f[1] && m_out == MAXO) return 0;
        return 1;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit          dv, rdy, inc;
        logic [11:0] hf;
        dv  = m_dv();
        rdy = (q.size() < ELS);
        hf  = (q.size() > 0) ? ref_flags(q[0].ins) : 12'h0;
        inc = 0;
        if (flush_i) begin
            q.delete();
            m_fw = 0;
        end else begin
            if (m_fw) begin
                if (m_out == 0) m_fw = 0;
            end else if (q.size() > 0 && (hf[10] || hf[11]) && m_out != 0) begin
                m_fw = 1;
            end
            if (dv && dec_yumi_i) begin
                inc = hf[1];
                void'(q.pop_front());
            end
            if (instr_v_i && rdy) q.push_back('{instr_i, pc_i});
        end
        if (mem_resp_v_i && !inc) begin
            if (m_out == 0) m_err = 1;
            else m_out--;
        end else if (inc && !mem_resp_v_i) begin
            m_out++;
        end
    endtask

    task automatic check_outs();
        bit dv;
        dv = m_dv();
        chk("ready", instr_ready_o, q.size() < ELS);
        chk("dec_v", dec_v_o, dv);
        if (dv) begin
            chk("dec_instr", dec_instr_o, q[0].ins);
            chk("dec_pc", dec_pc_o, q[0].pc);
            chk("dec_flags", dec_flags_o, ref_flags(q[0].ins));
        end
        chk("outstanding", outstanding_o, m_out);
        chk("fence_stall", fence_stall_o, m_fw);
        chk("err", err_o, m_err);
    endtask

    task automatic tick();
        @(negedge clk_i);
        check_outs();
        @(posedge clk_i);
        #1;
        model_step();
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [PCW-1:0] pc,
                         input bit y, input bit fl, input bit rsp);
        instr_v_i    = v;
        instr_i      = ins;
        pc_i         = pc;
        dec_yumi_i   = y & m_dv();
        flush_i      = fl;
        mem_resp_v_i = rsp;
    endtask

    task automatic idle();
        drive(0, '0, '0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && q.size() > 0; i++) begin
            drive(0, '0, '0, 1, 0, 0);
            tick();
        end
        idle();
    endtask

    task automatic do_reset(input string tag);
        reset_n_i = 1'b0;
        instr_v_i = 0; instr_i = '0; pc_i = '0;
        flush_i = 0; dec_yumi_i = 0; mem_resp_v_i = 0;
        #1;
        chk({tag, "_dec_v"}, dec_v_o, 0);
        chk({tag, "_ready"}, instr_ready_o, 1);
        chk({tag, "_out"}, outstanding_o, 0);
        chk({tag, "_fstall"}, fence_stall_o, 0);
        chk({tag, "_err"}, err_o, 0);
        q.delete();
        m_out = 0; m_err = 0; m_fw = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        logic [6:0]  ops [11];
        int          k;
        ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPR, OPI, AMO, MISC};
        w = $urandom;
        k = $urandom_range(0, 15);
        if (k < 11)       w[6:0] = ops[k];
        else if (k == 11) w = 32'h0000000F;
        else if (k == 12) w = 32'h0000100F;
        else if (k == 13) begin w[31:25] = 7'b0000001; w[6:0] = OPR; end
        else if (k == 14) begin w[31:27] = 5'b00001; w[6:0] = AMO; end
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    initial begin
        #2;
        do_reset("por");

        // single ADD held at the head
        drive(1, ADD, 24'h100, 0, 0, 0);
        tick();
        idle();
        chk("add_v", dec_v_o, 1);
        chk("add_flags", dec_flags_o, 12'h0C1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("add_hold_flags", dec_flags_o, 12'h0C1);
            chk("add_hold_instr", dec_instr_o, ADD);
        end
        drain();

        // fill to full, 5th refused even with yumi in the same cycle
        for (int i = 0; i < 4; i++) begin
            drive(1, ADD, PCW'(i + 1), 0, 0, 0);
            tick();
        end
        idle();
        chk("full_ready", instr_ready_o, 0);
        drive(1, 32'h00000013, 24'h55, 1, 0, 0);
        #1;
        chk("full_yumi_ready", instr_ready_o, 0);
        tick();
        idle();
        chk("after_pop_ready", instr_ready_o, 1);
        drain();

        // fence waits for two loads to retire
        drive(1, LW, 24'h200, 0, 0, 0);   tick();
        drive(1, LW, 24'h204, 1, 0, 0);   tick();
        drive(1, FENCE, 24'h208, 1, 0, 0); tick();
        idle();
        chk("fence_head_dv", dec_v_o, 0);
        chk("fence_out2", outstanding_o, 2);
        tick();
        chk("fence_stall", fence_stall_o, 1);
        drive(0, '0, '0, 0, 0, 1); tick();
        drive(0, '0, '0, 0, 0, 1); tick();
        idle();
        chk("fence_out0", outstanding_o, 0);
        chk("fence_still_wait", dec_v_o, 0);
        tick();
        chk("fence_run", fence_stall_o, 0);
        chk("fence_dv", dec_v_o, 1);
        chk("fence_flag10", dec_flags_o[10], 1);
        drain();

        // outstanding limit with stores
        for (int i = 0; i < 4; i++) begin
            drive(1, SW, PCW'(24'h300 + i * 4), 0, 0, 0);
            tick();
        end
        drive(0, '0, '0, 1, 0, 0); tick();
        drive(0, '0, '0, 1, 0, 1); tick();
        chk("issue_resp_out", outstanding_o, 1);
        drive(0, '0, '0, 1, 0, 0); tick();
        idle();
        chk("max_dv", dec_v_o, 0);
        chk("max_out", outstanding_o, 2);
        tick();
        drive(0, '0, '0, 0, 0, 1); tick();
        idle();
        chk("unblock_dv", dec_v_o, 1);

        // flush with 3 entries and an enqueue in the flush cycle
        drive(1, ADD, 24'h400, 0, 0, 0); tick();
        drive(1, ADD, 24'h404, 0, 0, 0); tick();
        drive(1, ADD, 24'h408, 1, 1, 0); tick();
        idle();
        chk("flush_dv", dec_v_o, 0);
        chk("flush_ready", instr_ready_o, 1);
        chk("flush_out", outstanding_o, 1);
        tick();
        drive(0, '0, '0, 0, 0, 1); tick();
        idle();

        // random traffic
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 2) != 0, rnd_instr(), PCW'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                  (m_out > 0) && ($urandom_range(0, 2) == 0));
            tick();
        end
        idle();

        // response underflow, sticky error, then reset mid-queue
        do_reset("pre_err");
        drive(0, '0, '0, 0, 0, 1); tick();
        idle();
        chk("err_set", err_o, 1);
        chk("err_out0", outstanding_o, 0);
        repeat (3) tick();
        drive(1, ADD, 24'h500, 0, 0, 0); tick();
        drive(1, LW, 24'h504, 0, 0, 0);  tick();
        idle();
        #2;
        do_reset("mid");
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
